out_port_uart_tx: RTL and testbench

//  Downstream consumer of the picoMIPS CPU data-path output (ALU result bus).

---
 rtl/uart_pkg.sv | 15 +
 rtl/out_fifo.sv | 60 ++++++
 rtl/out_port_uart_tx.sv | 143 ++++++++++++++
 tb/tb_out_port_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the CPU output-port UART transmitter.
//   tx_state_t      : transmitter FSM states
//   UART_IDLE_LEVEL : level the serial line rests at between frames
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO buffering CPU result bytes ahead of the serialiser.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   push, data  : write data at the tail (ignored while full)
//   pop         : advance the head (ignored while empty)
//   head        : entry at the head, valid while !empty
//   count       : entries held; full/empty derive from it
module out_fifo #(
  parameter  int BUS_WIDTH  = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [BUS_WIDTH-1:0] data,
  input  logic                 pop,
  output logic [BUS_WIDTH-1:0] head,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; only the pointers and count define validity,
  // and leaving the array unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// Captures strobed CPU result bytes into a FIFO and serialises each as an
// 8N1-style frame (start 0, data LSB first, stop 1) on tx.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   in_data    : result byte from the CPU out_port
//   in_valid   : in_data should be transmitted
//   in_ready   : FIFO not full
//   tx         : registered serial line, idles high
//   busy       : frame in flight or bytes queued
//   fifo_count : entries queued
//   overflow   : sticky, a byte was offered while full
module out_port_uart_tx
  import uart_pkg::*;
#(
  parameter  int BUS_WIDTH    = 8,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int CLKS_PER_BIT = 434,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BUS_WIDTH - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [BUS_WIDTH-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 pop;
  logic [BUS_WIDTH-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 baud_done;

  out_fifo #(
    .BUS_WIDTH  (BUS_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .data  (in_data),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready  = !full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !empty;
  assign baud_done = (baud_q == BAUD_LAST);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Directed bench for out_port_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_out_port_uart_tx;

  localparam int BW  = 8;
  localparam int FD  = 4;
  localparam int CPB = 4;
  localparam int CW  = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int max_count = 0;

  out_port_uart_tx #(
    .BUS_WIDTH    (BW),
    .FIFO_DEPTH   (FD),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc is the index of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (int'(fifo_count) > max_count) max_count = int'(fifo_count);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present d so that it is captured on rising edge t; returns at the falling
  // edge after edge t. Must be called while positioned at a falling edge.
  task automatic push_at(input int t, input logic [BW-1:0] d);
    if (cyc > t - 1) begin
      vectors++;
      miscompares++;
      $display("FAIL push_at schedule: at edge %0d, required <= %0d", cyc, t - 1);
    end
    while (cyc < t - 1) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a start bit, then check all ten bit periods of the frame.
  // Returns at the falling edge of the last stop-bit cycle.
  task automatic recv_frame(input logic [BW-1:0] exp, input string tag, output int start_cyc);
    int         waited;
    logic [9:0] frame;
    logic       bad;
    logic       got;
    waited = 0;
    frame  = {1'b1, exp, 1'b0};
    start_cyc = -1;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start: tx=%b, required 0 within 400 cycles", tag, tx);
      return;
    end
    start_cyc = cyc;
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      got = frame[b];
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx !== frame[b]) begin
          bad = 1'b1;
          got = tx;
        end
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s bit %0d: tx=%b, required %b", tag, b, got, frame[b]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1)          begin miscompares++; $display("FAIL reset tx: %b, required 1", tx); end
    vectors++;
    if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset busy: %b, required 0", busy); end
    vectors++;
    if (fifo_count !== '0)    begin miscompares++; $display("FAIL reset fifo_count: %0d, required 0", fifo_count); end
    vectors++;
    if (overflow !== 1'b0)    begin miscompares++; $display("FAIL reset overflow: %b, required 0", overflow); end
    vectors++;
    if (in_ready !== 1'b1)    begin miscompares++; $display("FAIL reset in_ready: %b, required 1", in_ready); end
  endtask

  task automatic test_single_frame();
    int n;
    int s;
    n = cyc + 1;
    push_at(n, 8'hA5);
    vectors++;
    if (fifo_count !== CW'(1) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single push state: count=%0d busy=%b, required 1 1", fifo_count, busy);
    end
    recv_frame(8'hA5, "single A5", s);
    vectors++;
    if (s !== n + 1) begin miscompares++; $display("FAIL single latency: start edge %0d, required %0d", s, n + 1); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single busy in stop: %b, required 1", busy); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single end: busy=%b tx=%b, required 0 1", busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int s0, s1, s2;
    n = cyc + 1;
    max_count = 0;
    fork
      begin
        push_at(n,     8'h01);
        push_at(n + 1, 8'h02);
        push_at(n + 2, 8'h03);
      end
      begin
        recv_frame(8'h01, "b2b 01", s0);
        recv_frame(8'h02, "b2b 02", s1);
        recv_frame(8'h03, "b2b 03", s2);
      end
    join
    vectors++;
    if (s1 - s0 !== 41) begin miscompares++; $display("FAIL b2b spacing 1: %0d, required 41", s1 - s0); end
    vectors++;
    if (s2 - s1 !== 41) begin miscompares++; $display("FAIL b2b spacing 2: %0d, required 41", s2 - s1); end
    vectors++;
    if (max_count !== 2) begin miscompares++; $display("FAIL b2b peak count: %0d, required 2", max_count); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int n;
    int s;
    n = cyc + 1;
    fork
      begin
        for (int i = 0; i < 5; i++) push_at(n + i, 8'h10 + 8'(i));
        vectors++;
        if (fifo_count !== CW'(4) || in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf full: count=%0d in_ready=%b, required 4 0", fifo_count, in_ready);
        end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf early: %b, required 0", overflow); end
        push_at(n + 5, 8'h15);
        vectors++;
        if (overflow !== 1'b1 || fifo_count !== CW'(4)) begin
          miscompares++;
          $display("FAIL ovf drop: overflow=%b count=%0d, required 1 4", overflow, fifo_count);
        end
      end
      begin
        recv_frame(8'h10, "ovf 10", s);
        recv_frame(8'h11, "ovf 11", s);
        recv_frame(8'h12, "ovf 12", s);
        recv_frame(8'h13, "ovf 13", s);
        recv_frame(8'h14, "ovf 14", s);
      end
    join
    repeat (50) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) begin
      miscompares++;
      $display("FAIL ovf drained: tx=%b busy=%b count=%0d, required 1 0 0", tx, busy, fifo_count);
    end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf sticky: %b, required 1", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int  n;
    logic seen_low;
    n = cyc + 1;
    push_at(n, 8'hFF);
    push_at(n + 1, 8'hFF);
    while (cyc < n + 11) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || fifo_count !== CW'(1)) begin
      miscompares++;
      $display("FAIL midreset before: busy=%b count=%0d, required 1 1", busy, fifo_count);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (tx !== 1'b1 || fifo_count !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset after: tx=%b count=%0d busy=%b in_ready=%b overflow=%b, required 1 0 0 1 0",
               tx, fifo_count, busy, in_ready, overflow);
    end
    seen_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen_low = 1'b1;
    end
    vectors++;
    if (seen_low) begin miscompares++; $display("FAIL midreset quiet: line activity=1, required 0"); end
  endtask

  task automatic test_push_on_pop();
    int n;
    int sa, sb, sc;
    n = cyc + 1;
    fork
      begin
        push_at(n, 8'hC3);
        push_at(n + 3, 8'h3C);
        while (cyc < n + 41) @(negedge clk);
        vectors++;
        if (fifo_count !== CW'(1)) begin miscompares++; $display("FAIL pushpop before: count=%0d, required 1", fifo_count); end
        push_at(n + 42, 8'h5A);
        vectors++;
        if (fifo_count !== CW'(1)) begin miscompares++; $display("FAIL pushpop after: count=%0d, required 1", fifo_count); end
      end
      begin
        recv_frame(8'hC3, "pushpop C3", sa);
        recv_frame(8'h3C, "pushpop 3C", sb);
        recv_frame(8'h5A, "pushpop 5A", sc);
      end
    join
    vectors++;
    if (sb !== n + 42 || sc !== n + 83) begin
      miscompares++;
      $display("FAIL pushpop starts: %0d %0d, required %0d %0d", sb, sc, n + 42, n + 83);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_push_on_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
